// File: rtl/copro_mem_pkg.sv
// Shared definitions for the 6502 co-processor memory bridge.
//   state_t        : request FSM states (settle, wait for ack, done)
//   DEF_*          : default parameter values for the bridge
//   sat_inc16      : saturating 16-bit increment used by the stall counter
package copro_mem_pkg;

    typedef enum logic [1:0] {
        S_SETTLE = 2'd0,
        S_WAIT   = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam int         DEF_CLKEN_DIV = 8;
    localparam int         DEF_SETTLE    = 1;
    localparam int         DEF_MEM_AW    = 24;
    localparam logic [7:0] DEF_MEM_BASE  = 8'h10;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/copro_mem_bridge_if.sv
// Byte-wide request/acknowledge memory port between the bridge (master)
// and the shared memory controller (slave).
//   mem_req  : request, level, held until the ack cycle
//   mem_we   : 1 = write, 0 = read
//   mem_addr : full memory address
//   mem_din  : write data towards memory
//   mem_dout : read data from memory, valid with mem_ack
//   mem_ack  : one-cycle acknowledge
interface copro_mem_bridge_if #(
    parameter int MEM_AW = 24
);
    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_din,
        input  mem_dout, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_din,
        output mem_dout, mem_ack
    );
endinterface

// File: rtl/copro_clken_gen.sv
// CPU clock-enable generator. An 8-bit phase counter runs 0..CLKEN_DIV-1;
// it parks on the last phase while hold is high, which stretches the CPU
// cycle. A registered one-cycle pulse is issued when the last phase is
// left (i.e. at_last with hold low).
//   clk_cpu, reset : clock, synchronous active-high reset
//   hold           : keep the counter on its last phase
//   phase          : current phase value
//   at_last        : phase == CLKEN_DIV-1
//   cpu_clken      : registered one-cycle enable pulse
module copro_clken_gen #(
    parameter int CLKEN_DIV = 8
) (
    input  logic       clk_cpu,
    input  logic       reset,
    input  logic       hold,
    output logic [7:0] phase,
    output logic       at_last,
    output logic       cpu_clken
);
    localparam logic [7:0] LAST_PHASE = 8'(CLKEN_DIV - 1);

    logic [7:0] phase_reg;
    logic       clken_reg;

    assign at_last   = (phase_reg == LAST_PHASE);
    assign phase     = phase_reg;
    assign cpu_clken = clken_reg;

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            phase_reg <= 8'd0;
            clken_reg <= 1'b0;
        end else begin
            // Pulse only on the wrap, so two pulses are always at least
            // CLKEN_DIV cycles apart.
            clken_reg <= at_last && !hold;
            if (!at_last) begin
                phase_reg <= phase_reg + 8'd1;
            end else if (!hold) begin
                phase_reg <= 8'd0;
            end
        end
    end
endmodule

// File: rtl/copro_mem_bridge.sv
// Bridge from the co-processor's external RAM port to a shared byte-wide
// request/ack memory. Every CPU cycle becomes exactly one memory
// transaction (non-RAM cycles go out as reads whose data is ignored).
// cpu_clken is withheld until the transaction has completed, so a late
// memory stretches the CPU cycle instead of returning stale read data.
//   clk_cpu, reset      : clock, synchronous active-high reset
//   cpu_clken           : CPU enable pulse
//   ram_addr/_data_in/_wr : CPU address, write data, write strobe
//   ram_data_out        : read data back to the CPU
//   mem                 : memory port (master side)
//   stall_count         : saturating count of stretch cycles
module copro_mem_bridge
    import copro_mem_pkg::*;
#(
    parameter int                CLKEN_DIV = DEF_CLKEN_DIV,
    parameter int                SETTLE    = DEF_SETTLE,
    parameter int                MEM_AW    = DEF_MEM_AW,
    parameter logic [MEM_AW-17:0] MEM_BASE = (MEM_AW-16)'(DEF_MEM_BASE)
) (
    input  logic                clk_cpu,
    input  logic                reset,
    output logic                cpu_clken,
    input  logic [15:0]         ram_addr,
    input  logic [7:0]          ram_data_in,
    input  logic                ram_wr,
    output logic [7:0]          ram_data_out,
    copro_mem_bridge_if.master  mem,
    output logic [15:0]         stall_count
);
    state_t            state_reg, state_next;
    logic              req_reg, req_next;
    logic              we_reg, we_next;
    logic [MEM_AW-1:0] addr_reg, addr_next;
    logic [7:0]        din_reg, din_next;
    logic [7:0]        data_reg, data_next;
    logic [15:0]       stall_reg, stall_next;

    logic [7:0] phase;
    logic       at_last;
    logic       hold;

    // The phase counter may only wrap once the transaction is finished.
    assign hold = (state_reg != S_DONE);

    copro_clken_gen #(
        .CLKEN_DIV (CLKEN_DIV)
    ) u_clken (
        .clk_cpu   (clk_cpu),
        .reset     (reset),
        .hold      (hold),
        .phase     (phase),
        .at_last   (at_last),
        .cpu_clken (cpu_clken)
    );

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        din_next   = din_reg;
        data_next  = data_reg;
        stall_next = stall_reg;

        case (state_reg)
            S_SETTLE: begin
                // CPU outputs have had SETTLE cycles to become valid.
                if (phase == 8'(SETTLE)) begin
                    addr_next  = {MEM_BASE, ram_addr};
                    we_next    = ram_wr;
                    din_next   = ram_data_in;
                    req_next   = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // Fields stay frozen until the ack; acks in other states
                // are spurious and deliberately ignored.
                if (mem.mem_ack) begin
                    req_next = 1'b0;
                    if (!we_reg) begin
                        data_next = mem.mem_dout;
                    end
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (at_last) begin
                    state_next = S_SETTLE;
                end
            end
            default: state_next = S_SETTLE;
        endcase

        // Every cycle parked on the last phase is one cycle of stretch.
        if (at_last && hold) begin
            stall_next = sat_inc16(stall_reg);
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state_reg <= S_SETTLE;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            din_reg   <= 8'd0;
            data_reg  <= 8'h00;
            stall_reg <= 16'd0;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            din_reg   <= din_next;
            data_reg  <= data_next;
            stall_reg <= stall_next;
        end
    end

    assign mem.mem_req   = req_reg;
    assign mem.mem_we    = we_reg;
    assign mem.mem_addr  = addr_reg;
    assign mem.mem_din   = din_reg;
    assign ram_data_out  = data_reg;
    assign stall_count   = stall_reg;
endmodule

// File: tb/tb_copro_mem_bridge.sv
// Self-checking bench for copro_mem_bridge: directed and randomized CPU
// cycles against a per-transaction model of period, stall and data.
module tb_copro_mem_bridge;
    localparam int DIV  = 8;
    localparam int SET  = 1;
    localparam int FAST = DIV - SET - 2;   // largest latency with no stretch

    logic        clk_cpu = 1'b0;
    logic        reset   = 1'b1;
    logic        cpu_clken;
    logic [15:0] ram_addr    = 16'h0000;
    logic [7:0]  ram_data_in = 8'h00;
    logic        ram_wr      = 1'b0;
    logic [7:0]  ram_data_out;
    logic [15:0] stall_count;

    copro_mem_bridge_if #(.MEM_AW(24)) mbus ();

    copro_mem_bridge dut (
        .clk_cpu      (clk_cpu),
        .reset        (reset),
        .cpu_clken    (cpu_clken),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_wr       (ram_wr),
        .ram_data_out (ram_data_out),
        .mem          (mbus),
        .stall_count  (stall_count)
    );

    always #5 clk_cpu = ~clk_cpu;

    int unsigned cyc = 0;
    always @(posedge clk_cpu) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    int unsigned last_pulse = 0;
    logic [7:0]  m_data = 8'h00;
    int unsigned m_stall = 0;
    int          txn = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_cpu);
        #1;
    endtask

    // One CPU cycle: present inputs, answer the request after lat cycles,
    // then check the clken period, read data and stall count.
    task automatic do_cycle(input logic [15:0] a, input logic wr, input logic [7:0] d,
                            input int lat, input logic [7:0] rd, input logic spur);
        logic [23:0] ea;
        int unsigned extra;
        int unsigned period;
        bit          ok;
        ram_addr    = a;
        ram_wr      = wr;
        ram_data_in = d;
        ea = {8'h10, a};
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            if (mbus.mem_req === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            chk("req_timeout", 32'd0, 32'd1);
            return;
        end
        chk("mem_addr", 32'(mbus.mem_addr), 32'(ea));
        chk("mem_we", 32'(mbus.mem_we), 32'(wr));
        if (wr) chk("mem_din", 32'(mbus.mem_din), 32'(d));
        chk("data_hold_req", 32'(ram_data_out), 32'(m_data));
        for (int i = 1; i < lat; i++) begin
            step();
            chk("wait_fields", {6'd0, mbus.mem_req, mbus.mem_we, mbus.mem_addr},
                {6'd0, 1'b1, wr, ea});
        end
        mbus.mem_ack  = 1'b1;
        mbus.mem_dout = rd;
        step();
        mbus.mem_ack = 1'b0;
        chk("req_drop", 32'(mbus.mem_req), 32'd0);

        if (!wr) m_data = rd;
        extra   = (lat > FAST) ? 32'(lat - FAST) : 32'd0;
        m_stall = (m_stall + extra > 32'd65535) ? 32'd65535 : m_stall + extra;
        chk("data_after_ack", 32'(ram_data_out), 32'(m_data));

        if (spur) begin
            mbus.mem_ack  = 1'b1;
            mbus.mem_dout = ~rd;
        end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            mbus.mem_ack = 1'b0;
            if (cpu_clken === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            chk("clken_timeout", 32'd0, 32'd1);
            return;
        end
        period = cyc - last_pulse;
        last_pulse = cyc;
        chk("period", period, 32'(DIV) + extra);
        chk("data_at_clken", 32'(ram_data_out), 32'(m_data));
        chk("stall_count", 32'(stall_count), m_stall);

        if (spur) begin
            mbus.mem_ack  = 1'b1;
            mbus.mem_dout = ~m_data;
        end
        step();
        mbus.mem_ack = 1'b0;
        chk("clken_single", 32'(cpu_clken), 32'd0);
        chk("data_after_clken", 32'(ram_data_out), 32'(m_data));
        txn++;
        $display("txn %0d addr %h wr %0d lat %0d spur %0d period %0d data %h stall %0d",
                 txn, a, wr, lat, spur, period, ram_data_out, stall_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        mbus.mem_ack  = 1'b0;
        mbus.mem_dout = 8'h00;

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        chk("rst_clken", 32'(cpu_clken), 32'd0);
        chk("rst_req", 32'(mbus.mem_req), 32'd0);
        chk("rst_we", 32'(mbus.mem_we), 32'd0);
        chk("rst_addr", 32'(mbus.mem_addr), 32'd0);
        chk("rst_din", 32'(mbus.mem_din), 32'd0);
        chk("rst_data", 32'(ram_data_out), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);

        // Spurious ack right after reset release
        reset = 1'b0;
        last_pulse = cyc;
        m_data = 8'h00;
        m_stall = 0;
        mbus.mem_ack  = 1'b1;
        mbus.mem_dout = 8'h77;
        step();
        mbus.mem_ack = 1'b0;
        chk("ack_after_rst", 32'(ram_data_out), 32'd0);

        // Nominal cadence, ack 2 cycles after request
        do_cycle(16'h0100, 1'b0, 8'h00, 2, 8'h11, 1'b0);
        do_cycle(16'h0101, 1'b0, 8'h00, 2, 8'h22, 1'b0);
        do_cycle(16'h1234, 1'b0, 8'h00, 2, 8'hA5, 1'b0);
        do_cycle(16'hFFFE, 1'b1, 8'h3C, 2, 8'h5A, 1'b0);
        // Slow memory and stretch boundaries
        do_cycle(16'h4000, 1'b0, 8'h00, 10, 8'h81, 1'b0);
        do_cycle(16'h4001, 1'b1, 8'h42, 10, 8'h00, 1'b0);
        do_cycle(16'h4002, 1'b0, 8'h00, FAST, 8'hC3, 1'b0);
        do_cycle(16'h4003, 1'b0, 8'h00, FAST + 1, 8'h3D, 1'b0);
        do_cycle(16'h4004, 1'b0, 8'h00, 1, 8'h6E, 1'b0);
        // Spurious acks in DONE and SETTLE
        do_cycle(16'h5000, 1'b0, 8'h00, 3, 8'h99, 1'b1);
        do_cycle(16'h5001, 1'b1, 8'h17, 7, 8'h00, 1'b1);

        // Reset while waiting for an ack, ack arrives one cycle later
        ram_addr = 16'h4321;
        ram_wr   = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            if (mbus.mem_req === 1'b1) ok = 1'b1;
        end
        if (!ok) chk("req_timeout_rst", 32'd0, 32'd1);
        step();
        reset = 1'b1;
        step();
        chk("midrst_req", 32'(mbus.mem_req), 32'd0);
        chk("midrst_data", 32'(ram_data_out), 32'd0);
        chk("midrst_stall", 32'(stall_count), 32'd0);
        chk("midrst_clken", 32'(cpu_clken), 32'd0);
        reset = 1'b0;
        last_pulse = cyc;
        m_data = 8'h00;
        m_stall = 0;
        mbus.mem_ack  = 1'b1;
        mbus.mem_dout = 8'hEE;
        step();
        mbus.mem_ack = 1'b0;
        chk("late_ack_ignored", 32'(ram_data_out), 32'd0);
        do_cycle(16'h2000, 1'b1, 8'h99, 2, 8'h00, 1'b0);
        do_cycle(16'h2001, 1'b0, 8'h00, 2, 8'h4B, 1'b0);

        // Randomized cycles
        for (int k = 0; k < 40; k++) begin
            do_cycle(16'($urandom), 1'($urandom), 8'($urandom),
                     int'($urandom_range(12, 1)), 8'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
